// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register sitting directly upstream of the ALU.
//
// Registers decoded operands and control from decode, turns ALUOp/funct into
// the 3-bit ALUControl, and selects the final A/B operands for the ALU.
// Memory and writeback control ride along to later stages.
//
// Optional feature: define ID_EX_FORWARDING_EN to forward results from the
// EX/MEM and MEM/WB stages. EX/MEM wins over MEM/WB. Register 0 is never
// forwarded. Without the macro the forwarding ports are present but ignored.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   stall, flush           hold all registers; load a bubble (flush wins)
//   id_*                   decoded instruction from the decode stage
//   exmem_*, memwb_*       forwarding sources (valid, destination, data)
//   A, B, ALUControl       operands and operation presented to the ALU
//   ex_valid, ex_wreg      slot valid; destination register index
//   ex_store_data          forwarded rt value for stores
//   ex_regwrite/memread/memwrite/memtoreg  registered downstream control
module id_ex_stage #(
   parameter int unsigned W  = 32,
   parameter int unsigned RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [W-1:0]  id_rs_data,
   input  logic [W-1:0]  id_rt_data,
   input  logic [W-1:0]  id_imm,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [1:0]    id_aluop,
   input  logic [5:0]    id_funct,
   input  logic          id_alusrc,
   input  logic          id_regdst,
   input  logic          id_regwrite,
   input  logic          id_memread,
   input  logic          id_memwrite,
   input  logic          id_memtoreg,
   input  logic          exmem_regwrite,
   input  logic          memwb_regwrite,
   input  logic [RW-1:0] exmem_rd,
   input  logic [RW-1:0] memwb_rd,
   input  logic [W-1:0]  exmem_result,
   input  logic [W-1:0]  memwb_result,
   output logic [W-1:0]  A,
   output logic [W-1:0]  B,
   output logic [2:0]    ALUControl,
   output logic          ex_valid,
   output logic [RW-1:0] ex_wreg,
   output logic [W-1:0]  ex_store_data,
   output logic          ex_regwrite,
   output logic          ex_memread,
   output logic          ex_memwrite,
   output logic          ex_memtoreg
);

   typedef struct packed {
      logic          valid;
      logic [W-1:0]  rs_data;
      logic [W-1:0]  rt_data;
      logic [W-1:0]  imm;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] wreg;
      logic [2:0]    alu_ctrl;
      logic          alusrc;
      logic          regwrite;
      logic          memread;
      logic          memwrite;
      logic          memtoreg;
   } ex_reg_t;

   ex_reg_t     ex_d, ex_q;
   logic [2:0]  alu_ctrl_dec;
   logic [W-1:0] rs_fwd, rt_fwd;

   // ALUOp/funct decode
   always_comb begin
      alu_ctrl_dec = 3'b010;
      unique case (id_aluop)
         2'b00: alu_ctrl_dec = 3'b010;
         2'b01: alu_ctrl_dec = 3'b110;
         2'b11: alu_ctrl_dec = 3'b001;
         2'b10: begin
            case (id_funct)
               6'b100000: alu_ctrl_dec = 3'b010;
               6'b100010: alu_ctrl_dec = 3'b110;
               6'b100100: alu_ctrl_dec = 3'b000;
               6'b100101: alu_ctrl_dec = 3'b001;
               6'b101010: alu_ctrl_dec = 3'b111;
               default:   alu_ctrl_dec = 3'b010;
            endcase
         end
         default: alu_ctrl_dec = 3'b010;
      endcase
   end

   // Next state: flush > stall > load; an invalid decode slot loads as a bubble
   always_comb begin
      ex_d = ex_q;
      if (flush) begin
         ex_d = '0;
      end else if (!stall) begin
         if (id_valid) begin
            ex_d.valid    = 1'b1;
            ex_d.rs_data  = id_rs_data;
            ex_d.rt_data  = id_rt_data;
            ex_d.imm      = id_imm;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.wreg     = id_regdst ? id_rd : id_rt;
            ex_d.alu_ctrl = alu_ctrl_dec;
            ex_d.alusrc   = id_alusrc;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            ex_d.memwrite = id_memwrite;
            ex_d.memtoreg = id_memtoreg;
         end else begin
            ex_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

`ifdef ID_EX_FORWARDING_EN
   always_comb begin
      rs_fwd = ex_q.rs_data;
      if (exmem_regwrite && (exmem_rd == ex_q.rs) && (ex_q.rs != '0)) begin
         rs_fwd = exmem_result;
      end else if (memwb_regwrite && (memwb_rd == ex_q.rs) && (ex_q.rs != '0)) begin
         rs_fwd = memwb_result;
      end
   end

   always_comb begin
      rt_fwd = ex_q.rt_data;
      if (exmem_regwrite && (exmem_rd == ex_q.rt) && (ex_q.rt != '0)) begin
         rt_fwd = exmem_result;
      end else if (memwb_regwrite && (memwb_rd == ex_q.rt) && (ex_q.rt != '0)) begin
         rt_fwd = memwb_result;
      end
   end
`else
   assign rs_fwd = ex_q.rs_data;
   assign rt_fwd = ex_q.rt_data;

   logic unused_fwd;
   assign unused_fwd = ^{exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
                         exmem_result, memwb_result, ex_q.rs, ex_q.rt};
`endif

   assign A             = rs_fwd;
   assign B             = ex_q.alusrc ? ex_q.imm : rt_fwd;
   assign ex_store_data = rt_fwd;
   assign ALUControl    = ex_q.alu_ctrl;
   assign ex_valid      = ex_q.valid;
   assign ex_wreg       = ex_q.wreg;
   assign ex_regwrite   = ex_q.regwrite;
   assign ex_memread    = ex_q.memread;
   assign ex_memwrite   = ex_q.memwrite;
   assign ex_memtoreg   = ex_q.memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush, id_valid;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [1:0]  id_aluop;
   logic [5:0]  id_funct;
   logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic [31:0] A, B, ex_store_data;
   logic [2:0]  ALUControl;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
   logic [4:0]  ex_wreg;

   int checks = 0;
   int errors = 0;

   // Reference model: the instruction currently held in the EX slot
   logic        m_valid, m_alusrc, m_rw, m_mr, m_mw, m_mt;
   logic [31:0] m_rs_data, m_rt_data, m_imm;
   logic [4:0]  m_rs, m_rt, m_wreg;
   logic [2:0]  m_ctl;

   id_ex_stage #(.W(32), .RW(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluop(id_aluop),
      .id_funct(id_funct), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
      .id_memtoreg(id_memtoreg), .exmem_regwrite(exmem_regwrite),
      .memwb_regwrite(memwb_regwrite), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_result(exmem_result), .memwb_result(memwb_result),
      .A(A), .B(B), .ALUControl(ALUControl), .ex_valid(ex_valid), .ex_wreg(ex_wreg),
      .ex_store_data(ex_store_data), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] decode(input logic [1:0] op, input logic [5:0] fn);
      if (op == 2'd0) return 3'b010;
      if (op == 2'd1) return 3'b110;
      if (op == 2'd3) return 3'b001;
      if (fn == 6'd32) return 3'b010;  // add
      if (fn == 6'd34) return 3'b110;  // sub
      if (fn == 6'd36) return 3'b000;  // and
      if (fn == 6'd37) return 3'b001;  // or
      if (fn == 6'd42) return 3'b111;  // slt
      return 3'b010;
   endfunction

   function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] regval);
`ifdef ID_EX_FORWARDING_EN
      if (idx != 0 && exmem_regwrite && exmem_rd == idx) return exmem_result;
      if (idx != 0 && memwb_regwrite && memwb_rd == idx) return memwb_result;
`endif
      return regval;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (reset || flush || (!stall && !id_valid)) begin
         {m_valid, m_alusrc, m_rw, m_mr, m_mw, m_mt} = '0;
         {m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_wreg, m_ctl} = '0;
      end else if (!stall) begin
         m_valid = 1'b1;
         m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
         m_rs = id_rs; m_rt = id_rt;
         m_wreg = id_regdst ? id_rd : id_rt;
         m_ctl = decode(id_aluop, id_funct);
         m_alusrc = id_alusrc; m_rw = id_regwrite; m_mr = id_memread;
         m_mw = id_memwrite; m_mt = id_memtoreg;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".A"}, A, fwd(m_rs, m_rs_data));
      chk({tag, ".B"}, B, m_alusrc ? m_imm : fwd(m_rt, m_rt_data));
      chk({tag, ".store"}, ex_store_data, fwd(m_rt, m_rt_data));
      chk({tag, ".aluctl"}, 32'(ALUControl), 32'(m_ctl));
      chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
      chk({tag, ".wreg"}, 32'(ex_wreg), 32'(m_wreg));
      chk({tag, ".ctrl"}, 32'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}),
          32'({m_rw, m_mr, m_mw, m_mt}));
   endtask

   // One clock: model follows the edge, outputs sampled 1 time unit later
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic rand_id();
      logic [5:0] fn_tab [6];
      fn_tab = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
      id_valid    = 1'b1;
      id_rs_data  = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_rd       = 5'($urandom);
      id_aluop    = 2'($urandom);
      id_funct    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 5)];
      {id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg} = 6'($urandom);
   endtask

   task automatic rand_fwd();
      exmem_regwrite = 1'($urandom); memwb_regwrite = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
      exmem_result = $urandom; memwb_result = $urandom;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      rand_id();
      rand_fwd();
      model_edge();

      // Reset with arbitrary inputs
      step("reset0");
      rand_id(); rand_fwd();
      step("reset1");
      chk("reset.valid", 32'(ex_valid), 32'd0);
      chk("reset.aluctl", 32'(ALUControl), 32'd0);
      chk("reset.A", A, 32'd0);
      reset = 1'b0;

      // Decode sweep
      rand_id(); id_aluop = 2'b10; id_funct = 6'b100010;
      step("dec_sub");
      chk("dec_sub.exp", 32'(ALUControl), 32'd6);
      rand_id(); id_aluop = 2'b10; id_funct = 6'b101010;
      step("dec_slt");
      chk("dec_slt.exp", 32'(ALUControl), 32'd7);
      rand_id(); id_aluop = 2'b10; id_funct = 6'b000000;
      step("dec_dflt");
      chk("dec_dflt.exp", 32'(ALUControl), 32'd2);
      rand_id(); id_aluop = 2'b11;
      step("dec_or");
      chk("dec_or.exp", 32'(ALUControl), 32'd1);

      // Operand select, no forwarding sources active
      exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
      rand_id(); id_rs_data = 32'd5; id_rt_data = 32'd7; id_imm = 32'hFFFF_FFFF;
      id_alusrc = 1'b1;
      step("opsel");
      chk("opsel.A", A, 32'd5);
      chk("opsel.B", B, 32'hFFFF_FFFF);
      chk("opsel.store", ex_store_data, 32'd7);

      // Stall holds, then flush wins over stall
      rand_id(); id_regwrite = 1'b1;
      step("load");
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_id();
         step("stall");
         chk("stall.valid", 32'(ex_valid), 32'd1);
         chk("stall.regwrite", 32'(ex_regwrite), 32'd1);
      end
      flush = 1'b1;
      step("flush");
      chk("flush.valid", 32'(ex_valid), 32'd0);
      chk("flush.ctrl", 32'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}), 32'd0);
      stall = 1'b0; flush = 1'b0;

      // Forwarding priority
      rand_id(); id_rs = 5'd3; id_rs_data = 32'h55;
      exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
      memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
      step("fwd_exmem");
`ifdef ID_EX_FORWARDING_EN
      chk("fwd_exmem.exp", A, 32'h11);
`else
      chk("fwd_exmem.exp", A, 32'h55);
`endif
      exmem_regwrite = 1'b0;
      #1;
      check_all("fwd_memwb");
`ifdef ID_EX_FORWARDING_EN
      chk("fwd_memwb.exp", A, 32'h22);
`else
      chk("fwd_memwb.exp", A, 32'h55);
`endif
      rand_id(); id_rs = 5'd0; id_rs_data = 32'h77;
      exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
      step("fwd_r0");
      chk("fwd_r0.exp", A, 32'h77);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rand_id();
         rand_fwd();
         id_valid = ($urandom_range(0, 7) != 0);
         stall    = ($urandom_range(0, 4) == 0);
         flush    = ($urandom_range(0, 9) == 0);
         reset    = ($urandom_range(0, 19) == 0);
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage directly upstream of `alu`: registers decoded operands and control from the decode stage, generates the 3-bit `ALUControl` from ALUOp/funct, and selects the final `A`/`B` operands presented to `alu`. It optionally forwards results from later stages, and carries memory/writeback control downstream alongside the ALU result. It supports pipeline stall (hold) and flush (bubble insertion).

## Interface
Parameters:
- `W`, 32, datapath width
- `RW`, 5, register-index width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  hold all pipeline registers
- `flush`  in  1  load a bubble
- `id_valid`  in  1  decode slot holds a real instruction
- `id_rs_data`, `id_rt_data`, `id_imm`  in  W  register-file operands; sign-extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  RW  register indices
- `id_aluop`  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or
- `id_funct`  in  6  R-type function field
- `id_alusrc`, `id_regdst`  in  1  B=imm; write index = rd (else rt)
- `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg`  in  1  downstream control
- `exmem_regwrite`, `memwb_regwrite`  in  1  forwarding source valid
- `exmem_rd`, `memwb_rd`  in  RW  forwarding destination index
- `exmem_result`, `memwb_result`  in  W  forwarding data
- `A`, `B`  out  W  operands to `alu`
- `ALUControl`  out  3  operation to `alu`
- `ex_valid`  out  1  EX slot holds a real instruction
- `ex_wreg`  out  RW  destination register index
- `ex_store_data`  out  W  (forwarded) rt value for stores
- `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_memtoreg`  out  1  registered control

## Operation
- ALUControl encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- Decode, registered at the edge: aluop 00→010, 01→110, 11→001. For aluop 10, funct 100000→010, 100010→110, 100100→000, 100101→001, 101010→111; any other funct→010.
- `ex_wreg` is registered `id_regdst ? id_rd : id_rt`.
- Rising-edge priority: reset > flush > stall > load.
  - Reset and flush zero every registered field, so `ex_valid`=0, all control outputs=0, `ALUControl`=000, and `ex_wreg`=0.
  - Stall holds every register.
  - Load captures all `id_*` inputs.
  - When `id_valid`=0 on load, the stage loads as a bubble: same zeroing as flush.
- `A` = forwarded rs value.
- `B` = `imm_q` if `alusrc_q`, else forwarded rt value.
- `ex_store_data` = forwarded rt value, independent of `alusrc_q`.

## Timing
- One-cycle latency: `id_*` sampled at edge N appears on outputs after edge N.
- `A`, `B`, and `ex_store_data` are combinational from registered state plus the forwarding inputs in the same cycle; no extra delay.
- After `reset` is released, outputs stay at their reset values until the first load edge.
- Reset asserted mid-stall overrides the stall.
- Flush and stall asserted together produce a bubble.

## Configuration
- Macro `ID_EX_FORWARDING_EN`, when defined, enables forwarding. For each of rs and rt:
  - Select `exmem_result` if `exmem_regwrite` and `exmem_rd`==index and index≠0.
  - Otherwise select `memwb_result` under the same conditions on the `memwb_*` inputs.
  - Otherwise use the registered register-file value.
  - EX/MEM has priority over MEM/WB.
- When the macro is undefined, the forwarding ports remain present but are ignored, and the registered register-file values are used directly.

## Test plan
- Reset: hold `reset`=1 with arbitrary inputs for 2 cycles. All outputs must be 0, with `ALUControl`=000 and `ex_valid`=0.
- Decode sweep: aluop=10 with funct 100010 → `ALUControl`=110 next cycle; funct 101010 → 111; funct 000000 → 010. aluop=11 → 001.
- Operand select: rs_data=5, rt_data=7, imm=−1, alusrc=1 → `A`=5, `B`=0xFFFFFFFF, `ex_store_data`=7.
- Stall/flush: load an instruction, then stall=1 for 3 cycles with changed inputs → outputs unchanged. Then flush=1 with stall=1 → `ex_valid`=0 and all control outputs 0.
- Forwarding (macro on):
  - rs=3 with exmem_rd=3, exmem_regwrite=1, exmem_result=0x11, memwb_rd=3, memwb_result=0x22 → `A`=0x11.
  - Drop exmem_regwrite → `A`=0x22.
  - rs=0 with all forwarding sources targeting register 0 → `A`=`id_rs_data` registered.
- Forwarding off (macro undefined): repeat the previous stimulus → `A` equals the registered rs value in every case.
